ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDRW, default pkg_ram::RAM_ADDRW, RAM byte-address width.
REQ-002 Parameter DATAW, default pkg_ram::RAM_QUAD, RAM data width.
REQ-003 Parameter SIZEW, default 7, access-size field width (size in bits: 8/16/32/64).
REQ-004 Parameter FETCH_LAT, default 1, cycles from mem_op=RAM_FETCH to valid mem_rdata (range 1..7).
REQ-005 clk  in  1  single clock; all logic on posedge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 boot_done  in  1  loader finished; gates requester 1.
REQ-008 reqN_valid  in  1  requester N (N=0 loader, N=1 CPU) access request, held until ack.
REQ-009 reqN_we  in  1  1=store, 0=fetch.
REQ-010 reqN_addr  in  ADDRW  byte address.
REQ-011 reqN_wdata  in  DATAW  store data, right-aligned.
REQ-012 reqN_size  in  SIZEW  access size.
REQ-013 reqN_ack  out  1  one-cycle completion pulse.
REQ-014 reqN_rdata  out  DATAW  fetch data, valid with ack; holds until next fetch ack to N.
REQ-015 mem_op  out  pkg_ram op type  RAM_NOP/RAM_FETCH/RAM_STORE, registered.
REQ-016 mem_addr, mem_data_in, mem_size  out  ADDRW/DATAW/SIZEW  registered RAM command fields.
REQ-017 mem_rdata  in  DATAW  RAM fetch result.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT, RESP; exactly one requester owns RAM from ISSUE until return to IDLE.
REQ-019 IDLE: if an eligible valid request exists, latch winner id and its we/addr/wdata/size, go ISSUE; else stay, mem_op=RAM_NOP.
REQ-020 Eligibility: req0 always; req1 only when boot_done=1 in the arbitration cycle.
REQ-021 ISSUE: drive mem_op=RAM_STORE or RAM_FETCH for exactly one cycle with latched fields; mem_op=RAM_NOP in every other state.
REQ-022 Store: reqN_ack pulses in the ISSUE cycle; next state IDLE (store throughput one per 2 cycles).
REQ-023 Fetch: ISSUE -> WAIT; WAIT counts FETCH_LAT-1 cycles (3-bit counter), then RESP samples mem_rdata into reqN_rdata and pulses reqN_ack; RESP -> IDLE.
REQ-024 Request fields are sampled only in IDLE; changes on reqN_* while owned are ignored.
REQ-025 Deassertion of reqN_valid before ack is illegal; the started access completes and ack still pulses.
REQ-026 Never both acks in one cycle; at most one access outstanding.
REQ-027 boot_done falling while req1 owns RAM: access completes; only subsequent req1 grants are blocked.
REQ-028 Simultaneous eligible req0 and req1 in IDLE resolved per REQ-034/REQ-035.

Reset
REQ-029 rst low asynchronously forces: state IDLE, mem_op=RAM_NOP, mem_addr=0, mem_data_in=0, mem_size=0, req0_ack=0, req1_ack=0, req0_rdata=0, req1_rdata=0, wait counter 0, round-robin pointer 0.
REQ-030 Reset mid-access aborts it with no ack; a pending request is re-arbitrated from IDLE after release.
REQ-031 First arbitration occurs on the first posedge with rst high.

Configuration
REQ-032 Macro RAM_ARB_RR_EN selects the arbitration policy.
REQ-033 Round-robin pointer: 1 bit, updated on each grant to the non-granted requester.
REQ-034 Without RAM_ARB_RR_EN: fixed priority, req0 wins every tie; no pointer register exists.
REQ-035 With RAM_ARB_RR_EN: tie goes to the requester named by the pointer; a lone eligible request always wins.

Verification
REQ-036 Loader stores 0xAB to addr 0x10, size 8 -> mem_op=RAM_STORE one cycle, mem_addr=0x10, mem_data_in=0xAB, req0_ack same cycle.
REQ-037 FETCH_LAT=3, req1 fetch addr 0x20, mem_rdata=0x1122334455667788, boot_done=1 -> req1_ack 4 cycles after ISSUE with req1_rdata=0x1122334455667788.
REQ-038 boot_done=0, req1_valid high for 20 cycles -> no req1 grant; boot_done=1 -> ISSUE on the next arbitration cycle.
REQ-039 req0 and req1 both valid continuously, 6 stores each -> fixed: all req0 first; RR_EN: strict alternation starting with req0.
REQ-040 rst low during WAIT of a req1 fetch -> mem_op=RAM_NOP and acks 0 immediately, no req1_ack; after release the held request is re-issued.

Source files
------------

// File: rtl/pkg_ram.sv
// Shared RAM interface definitions: default address/data widths and the command opcode type.
package pkg_ram;

    localparam int RAM_ADDRW = 16;
    localparam int RAM_QUAD  = 64;

    typedef enum logic [1:0] {
        RAM_NOP   = 2'd0,
        RAM_FETCH = 2'd1,
        RAM_STORE = 2'd2
    } ram_op_t;

endpackage

// File: rtl/ram_arbiter.sv
// Two-requester RAM arbiter (req0 = loader, req1 = CPU gated by boot_done), one access in flight.
// Define RAM_ARB_RR_EN for round-robin tie-breaking; default is fixed priority to req0.
module ram_arbiter #(
    parameter int ADDRW     = pkg_ram::RAM_ADDRW,
    parameter int DATAW     = pkg_ram::RAM_QUAD,
    parameter int SIZEW     = 7,
    parameter int FETCH_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 boot_done,

    input  logic                 req0_valid,
    input  logic                 req0_we,
    input  logic [ADDRW-1:0]     req0_addr,
    input  logic [DATAW-1:0]     req0_wdata,
    input  logic [SIZEW-1:0]     req0_size,
    output logic                 req0_ack,
    output logic [DATAW-1:0]     req0_rdata,

    input  logic                 req1_valid,
    input  logic                 req1_we,
    input  logic [ADDRW-1:0]     req1_addr,
    input  logic [DATAW-1:0]     req1_wdata,
    input  logic [SIZEW-1:0]     req1_size,
    output logic                 req1_ack,
    output logic [DATAW-1:0]     req1_rdata,

    output pkg_ram::ram_op_t     mem_op,
    output logic [ADDRW-1:0]     mem_addr,
    output logic [DATAW-1:0]     mem_data_in,
    output logic [SIZEW-1:0]     mem_size,
    input  logic [DATAW-1:0]     mem_rdata
);

    import pkg_ram::*;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    // Last WAIT count value; meaningless (and unused) when FETCH_LAT == 1.
    localparam logic [2:0] WAIT_LAST = 3'(FETCH_LAT - 2);

    logic [1:0]       state;
    logic             own_id;
    logic             own_we;
    logic [2:0]       wait_cnt;

    logic             el0;
    logic             el1;
    logic             grant_any;
    logic             grant1;
    logic             sel_we;
    logic [ADDRW-1:0] sel_addr;
    logic [DATAW-1:0] sel_wdata;
    logic [SIZEW-1:0] sel_size;

`ifdef RAM_ARB_RR_EN
    logic             rr_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= 1'b0;
        end else if (state == IDLE && grant_any) begin
            rr_ptr <= ~grant1;
        end
    end
`endif

    // A requester whose ack is showing this cycle is still holding valid; skip it.
    always_comb begin
        el0       = req0_valid & ~req0_ack;
        el1       = req1_valid & boot_done & ~req1_ack;
        grant_any = el0 | el1;
`ifdef RAM_ARB_RR_EN
        grant1    = el1 & (~el0 | rr_ptr);
`else
        grant1    = el1 & ~el0;
`endif
        sel_we    = grant1 ? req1_we    : req0_we;
        sel_addr  = grant1 ? req1_addr  : req0_addr;
        sel_wdata = grant1 ? req1_wdata : req0_wdata;
        sel_size  = grant1 ? req1_size  : req0_size;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            own_id      <= 1'b0;
            own_we      <= 1'b0;
            wait_cnt    <= '0;
            mem_op      <= RAM_NOP;
            mem_addr    <= '0;
            mem_data_in <= '0;
            mem_size    <= '0;
            req0_ack    <= 1'b0;
            req1_ack    <= 1'b0;
            req0_rdata  <= '0;
            req1_rdata  <= '0;
        end else begin
            mem_op   <= RAM_NOP;
            req0_ack <= 1'b0;
            req1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        own_id      <= grant1;
                        own_we      <= sel_we;
                        mem_addr    <= sel_addr;
                        mem_data_in <= sel_wdata;
                        mem_size    <= sel_size;
                        mem_op      <= sel_we ? RAM_STORE : RAM_FETCH;
                        if (sel_we) begin
                            req0_ack <= ~grant1;
                            req1_ack <= grant1;
                        end
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (own_we) begin
                        state <= IDLE;
                    end else if (FETCH_LAT > 1) begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end else begin
                        state <= RESP;
                    end
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                RESP: begin
                    if (own_id) begin
                        req1_rdata <= mem_rdata;
                        req1_ack   <= 1'b1;
                    end else begin
                        req0_rdata <= mem_rdata;
                        req0_ack   <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
